button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
Front end for push-button inputs on the board. It synchronizes a raw, bouncing, asynchronous button pin and debounces it. It produces a clean level, one-cycle press and release pulses, a long-press flag, and an 8-bit press counter. Its outputs feed the LED and counter logic that toggles state on each button event, so that logic sees exactly one event per physical press.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on btn_in; legal values are 2 or more.
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized cycles required to accept a change (10 ms at 50 MHz); legal values are 2 or more.
HOLD_CYCLES, 50000000, cycles in PRESSED before the long-press flag is raised (1 s at 50 MHz); legal values are 1 or more.
ACTIVE_LOW, 0, when 1, btn_in is inverted before synchronization (pressed = pin low).

Ports:
clk  input  1  system clock; all logic is in this single domain.
rst  input  1  synchronous, active-high reset.
btn_in  input  1  raw button pin, asynchronous to clk.
btn_level  output  1  debounced level; 1 while in PRESSED or RELEASE_WAIT.
press  output  1  one-cycle pulse on accepted press.
release  output  1  one-cycle pulse on accepted release.
held  output  1  long-press flag; set after HOLD_CYCLES in PRESSED, cleared with release.
hold_pulse  output  1  one-cycle pulse when held rises.
press_count  output  8  number of accepted presses since reset; wraps modulo 256.

Behaviour:
- Reset: when rst is high on a clk edge, all outputs, synchronizer flops and timers clear to 0 and the state goes to IDLE. Reset mid-debounce or mid-hold aborts that operation with no pulse. If btn_in is still pressed after reset, it is re-debounced from IDLE.
- Synchronizer: s = final flop of a SYNC_STAGES chain fed by (btn_in XOR ACTIVE_LOW). No combinational path from btn_in reaches any output.
- Debounce timer: width is clog2(DEBOUNCE_CYCLES). Hold timer: width is clog2(HOLD_CYCLES); it saturates and does not wrap.
- IDLE: if s=1, go to PRESS_WAIT with debounce timer=0.
- PRESS_WAIT, checked in this priority order:
  - if s=0, go to IDLE (bounce rejected, no output change);
  - else if timer==DEBOUNCE_CYCLES-1, go to PRESSED, assert press for one cycle, increment press_count, and clear the hold timer;
  - else increment the timer.
- PRESSED:
  - if s=0, go to RELEASE_WAIT with debounce timer=0 and the hold timer frozen;
  - else, when the hold timer reaches HOLD_CYCLES-1 and held=0, set held=1 and assert hold_pulse for one cycle;
  - otherwise increment the hold timer while below HOLD_CYCLES-1.
- RELEASE_WAIT, mirror of PRESS_WAIT:
  - if s=1, return to PRESSED. The hold timer resumes from its frozen value; no press pulse; press_count unchanged.
  - else if timer==DEBOUNCE_CYCLES-1, go to IDLE, assert release for one cycle, and clear held.
  - else increment the timer.
- Latency: btn_in high and stable, first sampled at edge k. press is high in the cycle after edge k+SYNC_STAGES+DEBOUNCE_CYCLES. Release latency is symmetric.
- All outputs are registered. press and release can never be high in the same cycle. hold_pulse coincides with neither of them.
- press_count wrap: 255 plus one press gives 0. There is no overflow flag.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change in either direction.

Decomposition:
- Shared package button_pkg holds:
  - the state encoding constants: IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3;
  - the press_count width constant BTN_CNT_W=8;
  - a clog2 function, reused by other board-input blocks.
- One sub-module, button_sync: a SYNC_STAGES-deep flop chain with synchronous reset. It is reused by future switch and encoder inputs.
- The FSM, timers and counter stay in button_debounce.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4 and HOLD_CYCLES=8.
1. Clean press: btn_in 0→1 at edge 10 and held → press is high for exactly 1 cycle after edge 16; press_count=1; btn_level=1 from the same cycle.
2. Bounce rejection: btn_in high for 3 cycles, low for 1, repeated 5 times, then low → press, release and hold_pulse never assert; press_count=0; state remains IDLE.
3. Long press: hold btn_in for 20 cycles after press → hold_pulse is high once, 8 cycles after press; held stays 1. Releasing then gives release=1 for one cycle after debounce, and held=0 in that same cycle.
4. Release bounce: while PRESSED, drop btn_in for 2 cycles, then restore → release never asserts; no second press; press_count stays unchanged.
5. Counter wrap: 256 clean press/release cycles → press_count goes 255→0 on the 256th press; press and release are never asserted together.
6. Reset mid-operation: assert rst for 1 cycle during PRESS_WAIT (timer=2) and separately during PRESSED with held=1 → all outputs are 0 the cycle after the reset edge, with no pulses. A still-held button yields press 4+2+1 cycles after rst deasserts.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for board push-button and switch input blocks.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int BTN_CNT_W = 8;

    function automatic int clog2(input longint value);
        int result = 0;
        for (int i = 0; i < 63; i++)
            if (value > (longint'(1) << i)) result = i + 1;
        return result;
    endfunction

endpackage

// File: rtl/button_sync.sv
// Multi-flop synchronizer for a single asynchronous board input.
module button_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], din};
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button front end: synchronize, debounce, and derive press/release/long-press events.
//
//   state        | meaning
//   -------------+---------------------------------------------------
//   IDLE         | button released and stable
//   PRESS_WAIT   | input went high, counting stable cycles to accept
//   PRESSED      | press accepted, hold timer running
//   RELEASE_WAIT | input went low, counting stable cycles; hold frozen
module button_debounce
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_in,
    output logic                 btn_level,
    output logic                 press,
    // "release" is a reserved word, hence the suffix
    output logic                 release_pulse,
    output logic                 held,
    output logic                 hold_pulse,
    output logic [BTN_CNT_W-1:0] press_count
);

    localparam int DB_W   = clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = (clog2(HOLD_CYCLES) > 0) ? clog2(HOLD_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic s;
    logic pin;

    btn_state_t           state, state_n;
    logic [DB_W-1:0]      db_timer, db_n;
    logic [HOLD_W-1:0]    hold_timer, hold_n;
    logic [BTN_CNT_W-1:0] cnt_n;
    logic                 held_n, press_n, rel_n, hp_n, level_n;

    assign pin = btn_in ^ (ACTIVE_LOW != 0);

    button_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pin),
        .dout (s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            db_timer      <= '0;
            hold_timer    <= '0;
            held          <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
            btn_level     <= 1'b0;
            press_count   <= '0;
        end else begin
            state         <= state_n;
            db_timer      <= db_n;
            hold_timer    <= hold_n;
            held          <= held_n;
            press         <= press_n;
            release_pulse <= rel_n;
            hold_pulse    <= hp_n;
            btn_level     <= level_n;
            press_count   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        db_n    = db_timer;
        hold_n  = hold_timer;
        held_n  = held;
        cnt_n   = press_count;
        press_n = 1'b0;
        rel_n   = 1'b0;
        hp_n    = 1'b0;

        case (state)
            IDLE: begin
                if (s) begin
                    state_n = PRESS_WAIT;
                    db_n    = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_n = IDLE;
                end else if (db_timer == DB_LAST) begin
                    state_n = PRESSED;
                    press_n = 1'b1;
                    cnt_n   = press_count + BTN_CNT_W'(1);
                    hold_n  = '0;
                end else begin
                    db_n = db_timer + DB_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_n = RELEASE_WAIT;
                    db_n    = '0;
                end else if (hold_timer == HOLD_LAST) begin
                    if (!held) begin
                        held_n = 1'b1;
                        hp_n   = 1'b1;
                    end
                end else begin
                    hold_n = hold_timer + HOLD_W'(1);
                end
            end
            RELEASE_WAIT: begin
                // hold timer is left untouched so a bounce resumes the long-press count
                if (s) begin
                    state_n = PRESSED;
                end else if (db_timer == DB_LAST) begin
                    state_n = IDLE;
                    rel_n   = 1'b1;
                    held_n  = 1'b0;
                end else begin
                    db_n = db_timer + DB_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        level_n = (state_n == PRESSED) || (state_n == RELEASE_WAIT);
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       btn_level, press, release_pulse, held, hold_pulse;
    logic [7:0] press_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    button_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .ACTIVE_LOW      (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press         (press),
        .release_pulse (release_pulse),
        .held          (held),
        .hold_pulse    (hold_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        btn;
        int          reps;
        logic [12:0] exp;
    } vec_t;

    // {press, release, hold_pulse, level, held, count}
    function automatic logic [12:0] pk(input logic p, input logic r, input logic h,
                                       input logic l, input logic hd, input logic [7:0] c);
        return {p, r, h, l, hd, c};
    endfunction

    function automatic logic [12:0] outs();
        return {press, release_pulse, hold_pulse, btn_level, held, press_count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic b);
        btn_in = b;
        @(posedge clk);
        #1;
    endtask

    // returns number of steps until the pulse is seen, 0 on timeout
    task automatic wait_press(input logic b, input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            step(b);
            if (press === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_release(input logic b, input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            step(b);
            if (release_pulse === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("press_with_release", 32'(press & release_pulse), 32'd0);
            check("hold_pulse_overlap", 32'(hold_pulse & (press | release_pulse)), 32'd0);
        end
    end

    vec_t tbl[9];

    initial begin
        int n;
        logic [7:0] exp_cnt;

        tbl[0] = '{btn: 1'b0, reps: 2, exp: pk(0, 0, 0, 0, 0, 8'd0)};
        tbl[1] = '{btn: 1'b1, reps: 6, exp: pk(0, 0, 0, 0, 0, 8'd0)};
        tbl[2] = '{btn: 1'b1, reps: 1, exp: pk(1, 0, 0, 1, 0, 8'd1)};
        tbl[3] = '{btn: 1'b1, reps: 7, exp: pk(0, 0, 0, 1, 0, 8'd1)};
        tbl[4] = '{btn: 1'b1, reps: 1, exp: pk(0, 0, 1, 1, 1, 8'd1)};
        tbl[5] = '{btn: 1'b1, reps: 3, exp: pk(0, 0, 0, 1, 1, 8'd1)};
        tbl[6] = '{btn: 1'b0, reps: 6, exp: pk(0, 0, 0, 1, 1, 8'd1)};
        tbl[7] = '{btn: 1'b0, reps: 1, exp: pk(0, 1, 0, 0, 0, 8'd1)};
        tbl[8] = '{btn: 1'b0, reps: 2, exp: pk(0, 0, 0, 0, 0, 8'd1)};

        // reset state
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        check("reset_outputs", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 8'd0)));
        rst = 1'b0;
        mon_en = 1'b1;

        // bounce rejection: 3 high / 1 low, five times
        for (int rep = 0; rep < 5; rep++) begin
            for (int j = 0; j < 4; j++) begin
                step(j < 3);
                check("bounce_quiet", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 8'd0)));
            end
        end
        for (int j = 0; j < 8; j++) begin
            step(1'b0);
            check("bounce_tail", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 8'd0)));
        end

        // clean press, long hold, clean release
        foreach (tbl[v]) begin
            for (int r = 0; r < tbl[v].reps; r++) begin
                step(tbl[v].btn);
                check($sformatf("table_vec%0d_rep%0d", v, r), 32'(outs()), 32'(tbl[v].exp));
            end
        end

        // release bounce: 2-cycle dropout while pressed, hold timer resumes
        wait_press(1'b1, 12, n);
        check("rb_press_latency", 32'(n), 32'd7);
        for (int j = 0; j < 2; j++) begin
            step(1'b0);
            check("rb_dropout", 32'({press, release_pulse, btn_level, press_count}),
                  32'({1'b0, 1'b0, 1'b1, 8'd2}));
        end
        for (int j = 1; j <= 10; j++) begin
            step(1'b1);
            check("rb_restored", 32'({press, release_pulse, btn_level, press_count}),
                  32'({1'b0, 1'b0, 1'b1, 8'd2}));
            check("rb_hold_pulse", 32'(hold_pulse), 32'(j == 9));
            check("rb_held", 32'(held), 32'(j >= 9));
        end
        wait_release(1'b0, 12, n);
        check("rb_release_latency", 32'(n), 32'd7);
        check("rb_after_release", 32'(outs()), 32'(pk(0, 1, 0, 0, 0, 8'd2)));
        step(1'b0);
        step(1'b0);

        // reset during PRESS_WAIT with timer at 2
        for (int j = 0; j < 5; j++) step(1'b1);
        rst = 1'b1;
        step(1'b1);
        check("rst_press_wait", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 8'd0)));
        rst = 1'b0;
        wait_press(1'b1, 12, n);
        check("rst_repress_latency", 32'(n), 32'd7);
        check("rst_repress_count", 32'(press_count), 32'd1);
        for (int j = 1; j <= 8; j++) begin
            step(1'b1);
            check("rst_hold", 32'(outs()),
                  32'(j == 8 ? pk(0, 0, 1, 1, 1, 8'd1) : pk(0, 0, 0, 1, 0, 8'd1)));
        end

        // reset while PRESSED with held set
        rst = 1'b1;
        step(1'b1);
        check("rst_pressed_held", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 8'd0)));
        rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step(1'b0);
            check("rst_quiet", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 8'd0)));
        end

        // counter wrap over 256 presses
        exp_cnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            wait_press(1'b1, 12, n);
            exp_cnt = exp_cnt + 8'd1;
            check("wrap_press_latency", 32'(n), 32'd7);
            check("wrap_count", 32'(press_count), 32'(exp_cnt));
            wait_release(1'b0, 12, n);
            check("wrap_release_latency", 32'(n), 32'd7);
        end
        check("wrap_to_zero", 32'(press_count), 32'd0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
